// File: rtl/cla_sub_pipe_pkg.sv
// Shared constants for the pipelined borrow-lookahead subtractor.
package cla_sub_pipe_pkg;

    localparam int DEFAULT_N = 8;

    // Indices into the per-stage valid vector.
    localparam int unsigned STAGE_LO = 0;
    localparam int unsigned STAGE_HI = 1;

endpackage

// File: rtl/cla_sub_pipe_if.sv
// Operand/result handshake bundle for cla_sub_pipe.
interface cla_sub_pipe_if
    import cla_sub_pipe_pkg::*;
#(
    parameter int N = DEFAULT_N
);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Diff;
    logic         Borrow;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Diff, Borrow
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Diff, Borrow
    );

endinterface

// File: rtl/cla_sub_pipe_bls_nbit.sv
// Combinational W-bit borrow-lookahead subtractor: diff = a - b - bin.
module bls_nbit #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   br;

    assign g = ~a & b;
    assign p = ~(a ^ b);

    // Each borrow is the flattened sum-of-products over all lower generate
    // terms, so no borrow depends on a previously computed borrow.
    always_comb begin
        logic acc;
        logic prod;
        br    = '0;
        br[0] = bin;
        acc   = 1'b0;
        prod  = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int unsigned k = 0; k <= i; k++) begin
                acc  = acc | (prod & g[i-k]);
                prod = prod & p[i-k];
            end
            br[i+1] = acc | (prod & bin);
        end
    end

    assign diff = a ^ b ^ br[W-1:0];
    assign bout = br[W];

endmodule

// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined N-bit subtractor with valid/ready handshaking.
module cla_sub_pipe
    import cla_sub_pipe_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input logic           clk,
    input logic           rst,
    cla_sub_pipe_if.slave bus
);

    localparam int H = N / 2;

    logic [1:0]   v;
    logic         ready1;
    logic         ready2;

    logic [H-1:0] lo_q;
    logic [H-1:0] ahi_q;
    logic [H-1:0] bhi_q;
    logic         bmid_q;

    logic [H-1:0] lo_d;
    logic [H-1:0] hi_d;
    logic         bmid_d;
    logic         bout_d;

    logic [N-1:0] diff_q;
    logic         borrow_q;

    bls_nbit #(.W(H)) u_lo (
        .a    (bus.A[H-1:0]),
        .b    (bus.B[H-1:0]),
        .bin  (1'b0),
        .diff (lo_d),
        .bout (bmid_d)
    );

    bls_nbit #(.W(H)) u_hi (
        .a    (ahi_q),
        .b    (bhi_q),
        .bin  (bmid_q),
        .diff (hi_d),
        .bout (bout_d)
    );

    assign ready2       = ~v[STAGE_HI] | bus.out_ready;
    assign ready1       = ~v[STAGE_LO] | ready2;
    assign bus.in_ready = ready1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v        <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            if (ready1) begin
                v[STAGE_LO] <= bus.in_valid;
                if (bus.in_valid) begin
                    lo_q   <= lo_d;
                    bmid_q <= bmid_d;
                    ahi_q  <= bus.A[N-1:H];
                    bhi_q  <= bus.B[N-1:H];
                end
            end
            if (ready2) begin
                v[STAGE_HI] <= v[STAGE_LO];
                if (v[STAGE_LO]) begin
                    diff_q   <= {hi_d, lo_q};
                    borrow_q <= bout_d;
                end
            end
        end
    end

    assign bus.out_valid = v[STAGE_HI];
    assign bus.Diff      = diff_q;
    assign bus.Borrow    = borrow_q;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Scoreboard bench for cla_sub_pipe: directed cases, backpressure, reset, random traffic.
module tb_cla_sub_pipe;
    import cla_sub_pipe_pkg::*;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cla_sub_pipe_if #(.N(N)) bus ();

    cla_sub_pipe #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [N:0] exp;
        int         acc_cyc;
        bit         lat;
    } entry_t;

    entry_t     sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    bit         lat_mode = 1'b0;
    bit         held     = 1'b0;
    logic [N:0] held_val;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer subtraction wrapped to N bits.
    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        int d;
        d = int'(a) - int'(b);
        if (d < 0) d += (1 << N);
        return {(a < b), d[N-1:0]};
    endfunction

    task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops on output transfers, checks stall stability, pushes on input transfers.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", {{N{1'b0}}, bus.out_valid}, 1);
                check("stall_data", {bus.Borrow, bus.Diff}, held_val);
                held = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got 0x%0h expected no output", {bus.Borrow, bus.Diff});
                end else begin
                    entry_t e;
                    e = sb.pop_front();
                    check("result", {bus.Borrow, bus.Diff}, e.exp);
                    if (e.lat) check("latency", (N+1)'(cyc - e.acc_cyc), 2);
                end
            end else if (bus.out_valid) begin
                held     = 1'b1;
                held_val = {bus.Borrow, bus.Diff};
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back('{model(bus.A, bus.B), cyc, lat_mode});
        end
    end

    task automatic drive(input bit r, input bit iv, input logic [N-1:0] a,
                         input logic [N-1:0] b, input bit ordy);
        @(posedge clk);
        #1;
        rst           = r;
        bus.in_valid  = iv;
        bus.A         = a;
        bus.B         = b;
        bus.out_ready = ordy;
    endtask

    function automatic logic [N-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return N'($urandom);
        endcase
    endfunction

    logic [N-1:0] da [8] = '{8'h05, 8'h03, 8'h10, 8'h00, 8'h00, 8'h5A, 8'hFF, 8'h01};
    logic [N-1:0] db [8] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h00, 8'h5A, 8'h00, 8'h02};
    logic [N-1:0] sa [4] = '{8'h80, 8'hFF, 8'h00, 8'h7F};
    logic [N-1:0] sbv[4] = '{8'h01, 8'hFF, 8'h00, 8'h80};

    initial begin
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", {{N{1'b0}}, bus.out_valid}, 0);
        check("rst_in_ready", {{N{1'b0}}, bus.in_ready}, 1);
        check("rst_diff", {1'b0, bus.Diff}, 0);
        check("rst_borrow", {{N{1'b0}}, bus.Borrow}, 0);

        // Isolated directed pairs, including boundary cases.
        lat_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, da[i], db[i], 1);
            repeat (3) drive(0, 0, '0, '0, 1);
        end

        // Back-to-back streaming; latency check forces consecutive outputs.
        for (int i = 0; i < 4; i++) drive(0, 1, sa[i], sbv[i], 1);
        repeat (4) drive(0, 0, '0, '0, 1);
        lat_mode = 1'b0;

        // Backpressure: two accepts then in_ready must drop.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, rand_operand(), rand_operand(), 0);
            @(negedge clk);
            check("bp_in_ready", {{N{1'b0}}, bus.in_ready}, (i < 2) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) drive(0, 1, rand_operand(), rand_operand(), 1);
        repeat (4) drive(0, 0, '0, '0, 1);

        // Reset with both stages full; nothing may emerge afterwards.
        drive(0, 1, 8'h44, 8'h11, 0);
        drive(0, 1, 8'h22, 8'h33, 0);
        drive(1, 1, 8'h99, 8'h01, 0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("midrst_out_valid", {{N{1'b0}}, bus.out_valid}, 0);
        check("midrst_in_ready", {{N{1'b0}}, bus.in_ready}, 1);
        repeat (5) drive(0, 0, '0, '0, 1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            ra = rand_operand();
            rb = ($urandom_range(0, 7) == 0) ? ra : rand_operand();
            drive(($urandom_range(0, 99) == 0), $urandom_range(0, 3) != 0, ra, rb,
                  $urandom_range(0, 2) != 0);
        end

        // Drain with a bounded wait.
        begin
            int budget;
            budget = 50;
            drive(0, 0, '0, '0, 1);
            while (sb.size() != 0 && budget > 0) begin
                drive(0, 0, '0, '0, 1);
                budget--;
            end
            @(negedge clk);
            check("drain_left", (N+1)'(sb.size()), 0);
        end
        repeat (4) drive(0, 0, '0, '0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_sub_pipe.md
CLA_SUB_PIPE -- requirements
Module: cla_sub_pipe

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits; even values >= 4 only.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand pair A/B is offered.
REQ-005 SHALL have port in_ready  output  1  block accepts the offered pair this cycle.
REQ-006 SHALL have port A  input  N  minuend, unsigned.
REQ-007 SHALL have port B  input  N  subtrahend, unsigned.
REQ-008 SHALL have port out_valid  output  1  Diff/Borrow hold a result.
REQ-009 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-010 SHALL have port Diff  output  N  (A - B) mod 2^N.
REQ-011 SHALL have port Borrow  output  1  1 when A < B, else 0.

Function
REQ-012 SHALL compute Diff and Borrow with borrow-lookahead logic, not ripple: per bit, generate g = ~a & b and propagate p = ~(a ^ b); borrow[i+1] = g[i] | (p[i] & borrow[i]); borrow[0] = 0.
REQ-013 SHALL use a two-stage pipeline. Stage 1 computes the low N/2 bits of Diff plus the borrow out of bit N/2-1. It registers those with the high halves of A and B.
REQ-014 Stage 2 SHALL compute the high N/2 bits of Diff, using the registered stage-1 borrow as its borrow-in. It registers the full Diff, and registers Borrow = borrow[N].
REQ-015 A transfer on the input occurs when in_valid & in_ready; a transfer on the output occurs when out_valid & out_ready.
REQ-016 Latency SHALL be exactly 2 cycles from input transfer to out_valid, when the pipeline is not stalled.
REQ-017 Throughput SHALL be one result per cycle while out_ready is held at 1.
REQ-018 Stage-advance rules:
- ready2 = ~v2 | out_ready.
- ready1 = ~v1 | ready2.
- in_ready = ready1.
A combinational ready path from out_ready to in_ready is permitted.
REQ-019 When v2 = 1 and out_ready = 0, SHALL hold out_valid, Diff and Borrow stable until the result is consumed.
REQ-020 While stalled, stage 1 SHALL hold its contents and SHALL NOT accept new data if v1 = 1.
REQ-021 When an output transfer and an input transfer occur in the same cycle, SHALL perform both with no bubble and no loss of data.
REQ-022 Stage valid bits SHALL update as follows:
- v1 takes the value of (in_valid & in_ready) whenever ready1 = 1.
- v2 takes the value of v1 whenever ready2 = 1.
REQ-023 Data registers SHALL load only when their stage advances with valid data; they are otherwise don't-care.
REQ-024 Boundary case 0 - 0 SHALL give Diff = 0 and Borrow = 0.
REQ-025 Boundary case 0 - (2^N-1) SHALL give Diff = 1 and Borrow = 1.
REQ-026 Boundary case A = B SHALL give Diff = 0 and Borrow = 0.

Reset
REQ-027 On rst = 1 at a clock edge, SHALL clear v1 and v2. As a result, out_valid = 0 and in_ready = 1 in the following cycle.
REQ-028 SHALL reset Diff = 0 and Borrow = 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight results, with no partial output.
REQ-030 SHALL ignore in_valid during the cycle in which rst = 1.

Structure
REQ-031 A shared package SHALL hold the default width constant and the stage-index constants.
REQ-032 SHALL instantiate one sub-module, bls_nbit: a combinational N/2-bit borrow-lookahead subtractor. Ports: a, b, bin, diff, bout.
REQ-033 Both pipeline stages SHALL instantiate bls_nbit.

Verification
REQ-034 Basic subtraction, N=8: A=0x05, B=0x03 -> two cycles later Diff=0x02, Borrow=0.
REQ-035 Borrow out, N=8: A=0x03, B=0x05 -> Diff=0xFE, Borrow=1.
REQ-036 Cross-half borrow, N=8: A=0x10, B=0x01 -> Diff=0x0F, Borrow=0. Also A=0x00, B=0xFF -> Diff=0x01, Borrow=1.
REQ-037 Streaming, N=8: 4 back-to-back pairs (0x80-0x01, 0xFF-0xFF, 0x00-0x00, 0x7F-0x80) with out_ready=1 -> results 0x7F/0, 0x00/0, 0x00/0, 0xFF/1 on four consecutive cycles.
REQ-038 Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 continuously -> in_ready drops to 0 after two accepts and Diff stays stable. Releasing out_ready then delivers results in order, with none lost or duplicated.
REQ-039 Reset mid-flight: assert rst with v1=v2=1 -> the next cycle shows out_valid=0 and in_ready=1, and no stale result ever appears afterward.
